// File: rtl/ring_monitor.sv
// Checks that a one-hot ring vector advances by exactly one left rotation per
// clock, tracks lock/fault status, and counts completed revolutions.
module ring_monitor #(
  parameter int W       = 4,
  parameter int CNT_W   = 8,
  parameter int LOCK_N  = 4,
  parameter int MAX_ERR = 2
) (
  input  logic                 c,
  input  logic                 rst,
  input  logic [W-1:0]         q,
  input  logic                 clr,
  output logic                 locked,
  output logic                 fault,
  output logic [$clog2(W)-1:0] pos,
  output logic                 rev_tick,
  output logic [CNT_W-1:0]     rev_cnt,
  output logic [1:0]           err_cnt
);

  localparam int PW = $clog2(W);
  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [3:0]   LOCK_LIM = 4'(LOCK_N);
  localparam logic [1:0]   ERR_LIM  = 2'(MAX_ERR);

  typedef enum logic [1:0] {UNLOCK, LOCKING, LOCKED, FAULT} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     qs_q, qp_q;
  logic [3:0]       lock_cnt_q, lock_cnt_d;
  logic [1:0]       err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] rev_cnt_q, rev_cnt_d;
  logic             rev_tick_q, rev_tick_d;

  logic onehot, good, wrap;

  // Step judgement compares the newest sample against the rotated previous one;
  // a zero previous sample rotates to zero and therefore can never match.
  always_comb begin
    onehot = (qs_q != '0) && ((qs_q & (qs_q - ONE)) == '0);
    good   = onehot && (qs_q == {qp_q[W-2:0], qp_q[W-1]});
    wrap   = good && qs_q[0];
  end

  always_comb begin
    pos = '0;
    if (onehot) begin
      for (int i = 0; i < W; i++) begin
        if (qs_q[i]) pos = PW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    err_cnt_d  = err_cnt_q;
    rev_cnt_d  = rev_cnt_q;
    rev_tick_d = 1'b0;
    unique case (state_q)
      UNLOCK: begin
        if (good) begin
          lock_cnt_d = 4'd1;
          if (LOCK_LIM == 4'd1) begin
            state_d   = LOCKED;
            err_cnt_d = 2'd0;
          end else begin
            state_d = LOCKING;
          end
        end
      end
      LOCKING: begin
        if (good) begin
          lock_cnt_d = lock_cnt_q + 4'd1;
          if (lock_cnt_q + 4'd1 == LOCK_LIM) begin
            state_d   = LOCKED;
            err_cnt_d = 2'd0;
          end
        end else begin
          state_d    = UNLOCK;
          lock_cnt_d = 4'd0;
        end
      end
      LOCKED: begin
        if (wrap) begin
          rev_cnt_d  = rev_cnt_q + 1'b1;
          rev_tick_d = 1'b1;
          err_cnt_d  = 2'd0;
        end else if (!good) begin
          err_cnt_d = err_cnt_q + 2'd1;
          if (err_cnt_q + 2'd1 == ERR_LIM) state_d = FAULT;
        end
      end
      FAULT: begin
        if (clr) begin
          state_d    = UNLOCK;
          lock_cnt_d = 4'd0;
          err_cnt_d  = 2'd0;
        end
      end
      default: state_d = UNLOCK;
    endcase
  end

  always_ff @(posedge c) begin
    if (!rst) begin
      qs_q       <= '0;
      qp_q       <= '0;
      state_q    <= UNLOCK;
      lock_cnt_q <= 4'd0;
      err_cnt_q  <= 2'd0;
      rev_cnt_q  <= '0;
      rev_tick_q <= 1'b0;
    end else begin
      qs_q       <= q;
      qp_q       <= qs_q;
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      err_cnt_q  <= err_cnt_d;
      rev_cnt_q  <= rev_cnt_d;
      rev_tick_q <= rev_tick_d;
    end
  end

  assign locked   = (state_q == LOCKED);
  assign fault    = (state_q == FAULT);
  assign rev_tick = rev_tick_q;
  assign rev_cnt  = rev_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_ring_monitor.sv
// Directed bench for ring_monitor (W=4, CNT_W=8, LOCK_N=4, MAX_ERR=2).
module tb_ring_monitor;

  logic       c;
  logic       rst;
  logic [3:0] q;
  logic       clr;
  logic       locked;
  logic       fault;
  logic [1:0] pos;
  logic       rev_tick;
  logic [7:0] rev_cnt;
  logic [1:0] err_cnt;

  int tests;
  int failed;

  ring_monitor #(.W(4), .CNT_W(8), .LOCK_N(4), .MAX_ERR(2)) dut (
    .c(c), .rst(rst), .q(q), .clr(clr),
    .locked(locked), .fault(fault), .pos(pos),
    .rev_tick(rev_tick), .rev_cnt(rev_cnt), .err_cnt(err_cnt)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  // Apply one vector, let one rising edge pass, then settle before sampling.
  task automatic step(input logic [3:0] v);
    q = v;
    @(posedge c);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".locked"},   32'(locked),   32'd0);
    chk({tag, ".fault"},    32'(fault),    32'd0);
    chk({tag, ".pos"},      32'(pos),      32'd0);
    chk({tag, ".rev_tick"}, 32'(rev_tick), 32'd0);
    chk({tag, ".rev_cnt"},  32'(rev_cnt),  32'd0);
    chk({tag, ".err_cnt"},  32'(err_cnt),  32'd0);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b0;
    clr    = 1'b0;
    q      = 4'b0000;

    // T1: reset with q toggling, then an all-zero ring never locks
    step(4'b1010);
    step(4'b0101);
    step(4'b1111);
    chk_zero("t1_reset");
    rst = 1'b1;
    for (int i = 0; i < 6; i++) step(4'b0000);
    chk("t1_zero_locked", 32'(locked), 32'd0);
    chk("t1_zero_pos",    32'(pos),    32'd0);

    // T2: clean rotation from zero history
    step(4'b0001);  chk("t2_pos0", 32'(pos), 32'd0);
    step(4'b0010);  chk("t2_pos1", 32'(pos), 32'd1);
    step(4'b0100);  chk("t2_pos2", 32'(pos), 32'd2);
    step(4'b1000);  chk("t2_pos3", 32'(pos), 32'd3);
    step(4'b0001);  chk("t2_not_yet_locked", 32'(locked), 32'd0);
    step(4'b0010);
    chk("t2_locked",       32'(locked),   32'd1);
    chk("t2_entry_notick", 32'(rev_tick), 32'd0);
    chk("t2_entry_rev",    32'(rev_cnt),  32'd0);
    step(4'b0100);
    step(4'b1000);
    step(4'b0001);  chk("t2_pre_wrap_tick", 32'(rev_tick), 32'd0);
    step(4'b0010);
    chk("t2_tick1", 32'(rev_tick), 32'd1);
    chk("t2_rev1",  32'(rev_cnt),  32'd1);
    step(4'b0100);  chk("t2_tick_pulse", 32'(rev_tick), 32'd0);

    // T3: one bad step (a repeated sample) inside a revolution
    step(4'b1000);
    step(4'b0001);
    step(4'b0010);  chk("t3_rev2", 32'(rev_cnt), 32'd2);
    step(4'b0100);
    step(4'b0100);
    step(4'b1000);
    chk("t3_err1",    32'(err_cnt), 32'd1);
    chk("t3_locked",  32'(locked),  32'd1);
    step(4'b0001);  chk("t3_err_hold", 32'(err_cnt), 32'd1);
    step(4'b0010);
    chk("t3_err_clr", 32'(err_cnt),  32'd0);
    chk("t3_rev3",    32'(rev_cnt),  32'd3);
    chk("t3_tick",    32'(rev_tick), 32'd1);

    // T4: 0110 in place of 0100 gives two bad steps -> fault
    step(4'b0110);
    step(4'b1000);  chk("t4_err1", 32'(err_cnt), 32'd1);
    step(4'b0001);
    chk("t4_fault",  32'(fault),   32'd1);
    chk("t4_unlock", 32'(locked),  32'd0);
    chk("t4_rev",    32'(rev_cnt), 32'd3);
    chk("t4_err2",   32'(err_cnt), 32'd2);
    step(4'b0010);
    step(4'b0100);
    step(4'b1000);
    step(4'b0001);
    step(4'b0010);
    chk("t4_fault_sticky", 32'(fault),    32'd1);
    chk("t4_rev_frozen",   32'(rev_cnt),  32'd3);
    chk("t4_no_tick",      32'(rev_tick), 32'd0);
    clr = 1'b1;
    step(4'b0100);
    clr = 1'b0;
    chk("t4_clr_fault", 32'(fault),   32'd0);
    chk("t4_clr_err",   32'(err_cnt), 32'd0);
    step(4'b1000);
    step(4'b0001);
    step(4'b0010);  chk("t4_relock_pending", 32'(locked), 32'd0);
    step(4'b0100);  chk("t4_relocked",       32'(locked), 32'd1);
    chk("t4_relock_rev", 32'(rev_cnt), 32'd3);

    // T5: two good steps then a stall drops back to UNLOCK
    rst = 1'b0;
    step(4'b0001);
    chk_zero("t5_reset");
    rst = 1'b1;
    step(4'b0001);
    step(4'b0010);
    step(4'b0100);
    step(4'b0100);
    step(4'b1000);
    step(4'b0001);
    step(4'b0010);
    step(4'b0100);  chk("t5_needs_fresh", 32'(locked), 32'd0);
    step(4'b1000);  chk("t5_relocked",    32'(locked), 32'd1);
    rst = 1'b0;
    step(4'b1000);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) step(4'b1000 >> (i % 4));
    chk("t5_reverse_locked", 32'(locked), 32'd0);
    chk("t5_reverse_fault",  32'(fault),  32'd0);

    // T6: 256+ revolutions, counter wrap, then reset mid-revolution
    rst = 1'b0;
    step(4'b0000);
    rst = 1'b1;
    for (int i = 0; i <= 1034; i++) begin
      step(4'b0001 << (i % 4));
      if (i == 1025) begin
        chk("t6_rev255",      32'(rev_cnt),  32'd255);
        chk("t6_tick255",     32'(rev_tick), 32'd1);
        chk("t6_locked",      32'(locked),   32'd1);
      end
      if (i == 1029) begin
        chk("t6_rev_wrap0",   32'(rev_cnt),  32'd0);
        chk("t6_tick_wrap",   32'(rev_tick), 32'd1);
      end
      if (i == 1033) chk("t6_rev_after_wrap", 32'(rev_cnt), 32'd1);
    end
    rst = 1'b0;
    step(4'b1000);
    chk_zero("t6_mid_reset");
    rst = 1'b1;
    step(4'b0001);
    step(4'b0010);
    step(4'b0100);
    chk("t6_relock_not_immediate", 32'(locked), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
